// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer and its load ports.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DEF_N = 8;
    localparam int DEF_W = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matmul_load_port.sv
// Per-reader acknowledge generator, element counter and matrix write enable.
module matmul_load_port
    import matmul_pkg::*;
#(
    parameter int NN = DEF_N * DEF_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic stb,
    output logic ack,
    output logic we,
    output logic full
);

    localparam int CW = $clog2(NN + 1);

    logic [CW-1:0] cnt_q;
    logic          ack_q;

    // Ack is a single-cycle pulse; the reader holds its element until it sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ack_q <= en & stb & ~ack_q & ~full;
            if (clr)
                cnt_q <= '0;
            else if (ack_q)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign full = (cnt_q == CW'(NN));
    assign ack  = ack_q;
    assign we   = ack_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Matrix-multiply controller: loads A/B, streams operand pairs to a MAC, forwards results.
// Optional MATMUL_SEQ_PERF_EN adds a saturating busy-cycle counter on cycle_count.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          rd_start,
    input  logic [IW-1:0] a_i,
    input  logic [IW-1:0] a_j,
    input  logic [W-1:0]  a_value,
    input  logic          a_stb,
    output logic          a_ack,
    input  logic [IW-1:0] b_i,
    input  logic [IW-1:0] b_j,
    input  logic [W-1:0]  b_value,
    input  logic          b_stb,
    output logic          b_ack,
    output logic [W-1:0]  op_a,
    output logic [W-1:0]  op_b,
    output logic          op_first,
    output logic          op_last,
    output logic          op_stb,
    input  logic          op_ack,
    input  logic [W-1:0]  res_value,
    input  logic          res_stb,
    output logic          res_ack,
    output logic [IW-1:0] out_i,
    output logic [IW-1:0] out_j,
    output logic [W-1:0]  out_value,
    output logic          out_stb,
    input  logic          out_ack,
    output logic          busy,
    output logic          done
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]   cycle_count
`endif
);

    localparam logic [IW-1:0] IMAX = IW'(N - 1);

    logic [W-1:0] mat_a [N][N];
    logic [W-1:0] mat_b [N][N];

    state_t        state_q;
    logic [IW-1:0] i_q, j_q, k_q, ri_q, rj_q, out_i_q, out_j_q;
    logic [W-1:0]  out_value_q;
    logic          rd_start_q, op_stb_q, res_ack_q, out_stb_q, busy_q, done_q;

    logic a_we, b_we, a_full, b_full, load_en, cnt_clr;
    logic op_xfer, out_xfer, last_op, res_ack_d;

    assign load_en = (state_q == S_LOAD);
    assign cnt_clr = (state_q == S_IDLE) & start;

    matmul_load_port #(.NN(N * N)) u_port_a (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(load_en),
        .stb(a_stb), .ack(a_ack), .we(a_we), .full(a_full)
    );

    matmul_load_port #(.NN(N * N)) u_port_b (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(load_en),
        .stb(b_stb), .ack(b_ack), .we(b_we), .full(b_full)
    );

    // Matrix storage is not reset: every run reloads all N*N elements first.
    always_ff @(posedge clk) begin
        if (a_we) mat_a[a_i][a_j] <= a_value;
        if (b_we) mat_b[b_i][b_j] <= b_value;
    end

    assign op_xfer  = op_stb_q & op_ack;
    assign out_xfer = out_stb_q & out_ack;
    assign last_op  = (i_q == IMAX) && (j_q == IMAX) && (k_q == IMAX);

    // A new result may be taken on the same edge that retires the held one.
    assign res_ack_d = ((state_q == S_COMPUTE) || (state_q == S_DRAIN)) &
                       res_stb & ~res_ack_q & (~out_stb_q | out_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            ri_q        <= '0;
            rj_q        <= '0;
            out_i_q     <= '0;
            out_j_q     <= '0;
            out_value_q <= '0;
            rd_start_q  <= 1'b0;
            op_stb_q    <= 1'b0;
            res_ack_q   <= 1'b0;
            out_stb_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_start_q <= 1'b0;
            done_q     <= 1'b0;
            res_ack_q  <= res_ack_d;

            if (res_ack_q) begin
                out_stb_q   <= 1'b1;
                out_value_q <= res_value;
                out_i_q     <= ri_q;
                out_j_q     <= rj_q;
            end else if (out_xfer) begin
                out_stb_q <= 1'b0;
            end

            if (out_xfer) begin
                if (rj_q == IMAX) begin
                    rj_q <= '0;
                    ri_q <= (ri_q == IMAX) ? '0 : ri_q + 1'b1;
                end else begin
                    rj_q <= rj_q + 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        rd_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        ri_q       <= '0;
                        rj_q       <= '0;
                    end
                end
                S_LOAD: begin
                    if (a_full && b_full) begin
                        state_q  <= S_COMPUTE;
                        op_stb_q <= 1'b1;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                    end
                end
                S_COMPUTE: begin
                    if (op_xfer) begin
                        if (last_op) begin
                            op_stb_q <= 1'b0;
                            state_q  <= S_DRAIN;
                        end
                        if (k_q == IMAX) begin
                            k_q <= '0;
                            if (j_q == IMAX) begin
                                j_q <= '0;
                                i_q <= (i_q == IMAX) ? '0 : i_q + 1'b1;
                            end else begin
                                j_q <= j_q + 1'b1;
                            end
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_xfer && (ri_q == IMAX) && (rj_q == IMAX)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_start  = rd_start_q;
    assign op_stb    = op_stb_q;
    assign op_a      = op_stb_q ? mat_a[i_q][k_q] : '0;
    assign op_b      = op_stb_q ? mat_b[k_q][j_q] : '0;
    assign op_first  = op_stb_q & (k_q == '0);
    assign op_last   = op_stb_q & (k_q == IMAX);
    assign res_ack   = res_ack_q;
    assign out_stb   = out_stb_q;
    assign out_i     = out_i_q;
    assign out_j     = out_j_q;
    assign out_value = out_value_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_q <= '0;
        else if (cnt_clr)
            cyc_q <= '0;
        else if (busy_q && (cyc_q != 32'hFFFF_FFFF))
            cyc_q <= cyc_q + 32'd1;
    end

    assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (N=4): reader, MAC and sink models driven on the falling edge.
module tb_matmul_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, rd_start;
    logic [1:0]  a_i, a_j, b_i, b_j, out_i, out_j;
    logic [31:0] a_value, b_value, op_a, op_b, res_value, out_value;
    logic        a_stb, a_ack, b_stb, b_ack, op_first, op_last, op_stb, op_ack;
    logic        res_stb, res_ack, out_stb, out_ack, busy, done;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] cycle_count;
`endif

    matmul_sequencer #(.N(N), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_start(rd_start),
        .a_i(a_i), .a_j(a_j), .a_value(a_value), .a_stb(a_stb), .a_ack(a_ack),
        .b_i(b_i), .b_j(b_j), .b_value(b_value), .b_stb(b_stb), .b_ack(b_ack),
        .op_a(op_a), .op_b(op_b), .op_first(op_first), .op_last(op_last),
        .op_stb(op_stb), .op_ack(op_ack),
        .res_value(res_value), .res_stb(res_stb), .res_ack(res_ack),
        .out_i(out_i), .out_j(out_j), .out_value(out_value), .out_stb(out_stb),
        .out_ack(out_ack), .busy(busy), .done(done)
`ifdef MATMUL_SEQ_PERF_EN
        , .cycle_count(cycle_count)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    // Test configuration (written by the main sequence only)
    logic [31:0] ma [4][4];
    logic [31:0] mb [4][4];
    int a_dly, b_dly, mac_lat;
    bit bp_en;

    // Model state (written by the monitor only)
    typedef struct { logic [31:0] v; int t; } res_t;
    res_t        rq [$];
    int          cyc = 0;
    int          a_idx, b_idx, a_go, b_go, a_acks, b_acks;
    bit          a_pend, b_pend, a_run, b_run, a_ack_prev, b_ack_prev;
    int          op_cnt, op_err, op_wait, out_cnt, viol, done_cnt, rd_cnt, busy_cyc, bp_left;
    bit          r_pend, bp_started, hold_prev;
    logic [31:0] acc;
    logic [35:0] prev_out;
    logic [31:0] got_v  [16];
    logic [3:0]  got_ij [16];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            a_idx = 0; b_idx = 0; a_go = 0; b_go = 0; a_acks = 0; b_acks = 0;
            a_pend = 0; b_pend = 0; a_run = 0; b_run = 0; a_ack_prev = 0; b_ack_prev = 0;
            op_cnt = 0; op_err = 0; op_wait = 0; out_cnt = 0; viol = 0; done_cnt = 0;
            rd_cnt = 0; busy_cyc = 0; bp_left = 0; r_pend = 0; bp_started = 0; hold_prev = 0;
            acc = 0; prev_out = 0;
            rq.delete();
            a_stb = 0; a_i = 0; a_j = 0; a_value = 0;
            b_stb = 0; b_i = 0; b_j = 0; b_value = 0;
            op_ack = 0; res_stb = 0; res_value = 0; out_ack = 0;
        end else begin
            if (rd_start) begin
                rd_cnt++;
                a_run = 1; b_run = 1;
                a_go = cyc + a_dly; b_go = cyc + b_dly;
            end
            // Readers: advance one element after each ack cycle has been captured
            if (a_pend) a_idx++;
            if (b_pend) b_idx++;
            a_pend = a_ack;
            b_pend = b_ack;
            if (a_ack) begin a_acks++; if (a_ack_prev) viol++; end
            if (b_ack) begin b_acks++; if (b_ack_prev) viol++; end
            a_ack_prev = a_ack;
            b_ack_prev = b_ack;
            a_stb   = a_run && (a_idx < 16) && (cyc >= a_go);
            a_i     = 2'((a_idx % 16) / 4);
            a_j     = 2'(a_idx % 4);
            a_value = ma[(a_idx % 16) / 4][a_idx % 4];
            b_stb   = b_run && (b_idx < 16) && (cyc >= b_go);
            b_i     = 2'((b_idx % 16) / 4);
            b_j     = 2'(b_idx % 4);
            b_value = mb[(b_idx % 16) / 4][b_idx % 4];

            // MAC: op_ack after mac_lat waiting cycles, result after 3 cycles
            if (op_stb && (a_acks < 16 || b_acks < 16)) viol++;
            if (op_stb) begin
                if (op_wait >= mac_lat) begin op_ack = 1; op_wait = 0; end
                else begin op_ack = 0; op_wait++; end
            end else begin
                op_ack = 0; op_wait = 0;
            end
            if (op_stb && op_ack) begin
                if (op_a !== ma[(op_cnt / 16) % 4][op_cnt % 4] ||
                    op_b !== mb[op_cnt % 4][(op_cnt / 4) % 4] ||
                    op_first !== ((op_cnt % 4) == 0) ||
                    op_last  !== ((op_cnt % 4) == 3))
                    op_err++;
                acc = (op_first ? 32'd0 : acc) + op_a * op_b;
                if (op_last) rq.push_back('{acc, cyc + 3});
                op_cnt++;
            end

            // Result handshake
            if (res_ack && (out_stb || !res_stb)) viol++;
            if (r_pend && rq.size() > 0) void'(rq.pop_front());
            r_pend    = res_ack;
            res_stb   = (rq.size() > 0) && (rq[0].t <= cyc);
            res_value = (rq.size() > 0) ? rq[0].v : 32'd0;

            // Output sink with optional initial backpressure
            if (bp_en && out_stb && !bp_started) begin bp_started = 1; bp_left = 20; end
            if (bp_left > 0) begin out_ack = 0; bp_left--; end
            else out_ack = 1;
            if (hold_prev && (!out_stb || {out_value, out_i, out_j} !== prev_out)) viol++;
            if (out_stb && out_ack) begin
                got_v[out_cnt % 16]  = out_value;
                got_ij[out_cnt % 16] = {out_i, out_j};
                out_cnt++;
            end
            hold_prev = out_stb && !out_ack;
            prev_out  = {out_value, out_i, out_j};

            if (done) done_cnt++;
            if (busy) busy_cyc++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_test(input string name, input int adly, input int bdly,
                            input int lat, input bit bp);
        logic [31:0] exp_c [4][4];
        bit got_done;
        a_dly = adly; b_dly = bdly; mac_lat = lat; bp_en = bp;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < 4; k++) exp_c[i][j] += ma[i][k] * mb[k][j];
            end
        do_reset();
        pulse_start();
        got_done = 0;
        for (int t = 0; t < 3000; t++) begin
            if (done) begin got_done = 1; break; end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check_eq({name, ".done_seen"}, 64'(got_done), 64'd1);
        check_eq({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
        check_eq({name, ".rd_start_pulses"}, 64'(rd_cnt), 64'd1);
        check_eq({name, ".a_acks"}, 64'(a_acks), 64'd16);
        check_eq({name, ".b_acks"}, 64'(b_acks), 64'd16);
        check_eq({name, ".op_transfers"}, 64'(op_cnt), 64'd64);
        check_eq({name, ".op_pair_errors"}, 64'(op_err), 64'd0);
        check_eq({name, ".protocol_violations"}, 64'(viol), 64'd0);
        check_eq({name, ".out_count"}, 64'(out_cnt), 64'd16);
        check_eq({name, ".busy_after"}, 64'(busy), 64'd0);
        for (int n = 0; n < 16; n++) begin
            check_eq($sformatf("%s.out_value[%0d]", name, n), 64'(got_v[n]), 64'(exp_c[n / 4][n % 4]));
            check_eq($sformatf("%s.out_index[%0d]", name, n), 64'(got_ij[n]), 64'(n));
        end
`ifdef MATMUL_SEQ_PERF_EN
        check_eq({name, ".cycle_count"}, 64'(cycle_count), 64'(busy_cyc));
        repeat (5) @(negedge clk);
        check_eq({name, ".cycle_count_hold"}, 64'(cycle_count), 64'(busy_cyc));
`endif
    endtask

    initial begin
        bit reached;
        rst_n = 0; start = 0;
        a_dly = 0; b_dly = 0; mac_lat = 2; bp_en = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
        repeat (2) @(negedge clk);
        check_eq("reset.outputs_zero", 64'(|{rd_start, a_ack, b_ack, op_stb, op_first, op_last,
                 res_ack, out_stb, busy, done, op_a, op_b, out_i, out_j, out_value}), 64'd0);

        // Identity times ramp: C must equal B
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 32'd1 : 32'd0;
                mb[i][j] = 32'(i * 4 + j + 1);
            end
        run_test("identity", 0, 0, 2, 0);

        // General matrices, reader B starts 40 cycles late
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 32'(i * 4 + j + 1);
                mb[i][j] = 32'(3 * i + 7 * j + 2);
            end
        run_test("skewed", 0, 40, 2, 0);

        run_test("backpressure", 0, 0, 2, 1);

        // Always-ready MAC, reader A late
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 32'h0001_0000 * 32'(i + 1) + 32'(j);
                mb[i][j] = 32'(17 - (i * 4 + j));
            end
        run_test("ready_mac", 5, 0, 0, 0);

        // Reset in the middle of COMPUTE, then a full run
        a_dly = 0; b_dly = 0; mac_lat = 1; bp_en = 0;
        do_reset();
        pulse_start();
        reached = 0;
        for (int t = 0; t < 2000; t++) begin
            if (op_cnt >= 10) begin reached = 1; break; end
            @(negedge clk);
        end
        check_eq("midreset.ops_reached", 64'(reached), 64'd1);
        #2 rst_n = 0;
        #1 check_eq("midreset.outputs_zero", 64'(|{rd_start, a_ack, b_ack, op_stb, op_first,
                   op_last, res_ack, out_stb, busy, done, op_a, op_b, out_i, out_j, out_value}), 64'd0);
        repeat (2) @(negedge clk);
        run_test("after_reset", 0, 3, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Top-level controller for the matrix-multiply datapath.
- Starts the two matrix file readers and captures their row-major element streams (A, B) into local arrays.
- Sequences N*N*N operand pairs into an external FP multiply-accumulate unit.
- Forwards the N*N results as an indexed output stream, then pulses done.

Parameters:
N, 8, matrix dimension (N >= 2); index width IW = $clog2(N)
W, 32, element width (IEEE-754 single bit pattern, passed through untouched)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a multiply; sampled only in IDLE
rd_start  out  1  one-cycle start pulse to both readers
a_i, a_j  in  IW each  element index from reader A
a_value  in  W  element value from reader A
a_stb  in  1  reader A value valid
a_ack  out  1  reader A acknowledge
b_i, b_j, b_value, b_stb  in  IW/IW/W/1  same as the A group, for reader B
b_ack  out  1  reader B acknowledge
op_a, op_b  out  W each  MAC operands: op_a = A[i][k], op_b = B[k][j]
op_first  out  1  k==0 (MAC clears its accumulator)
op_last  out  1  k==N-1 (MAC emits a result)
op_stb  out  1  operand pair valid
op_ack  in  1  MAC accepted the pair
res_value  in  W  MAC result
res_stb  in  1  MAC result valid
res_ack  out  1  result acknowledge
out_i, out_j  out  IW each  result coordinates
out_value  out  W  C[out_i][out_j]
out_stb  out  1  result valid
out_ack  in  1  downstream accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion

Behaviour:
- Reset (async assert, sync deassert by the user): state=IDLE. All outputs 0: rd_start, a_ack, b_ack, op_stb, op_first, op_last, res_ack, out_stb, busy, done, all index and value outputs.
- Reader handshake (A and B independently):
  - x_ack <= x_stb & ~x_ack, giving a single-cycle ack per element.
  - In the ack cycle, store x_value at mat_x[x_i][x_j].
  - x_ack is never asserted outside LOAD.
- Element count per port: one counter per port, up to N*N.
- States:
  - IDLE: on start, go to LOAD, rd_start=1 for exactly one cycle, clear the element counters. start is ignored in all other states.
  - LOAD: ack both streams. When both counters reach N*N (either order, or the same cycle), go to COMPUTE with i=j=k=0.
  - COMPUTE: op_stb=1 with operands and flags driven combinationally from registered i, j, k.
    - On op_stb&op_ack, advance k; at k wrap advance j; at j wrap advance i.
    - The transfer with i=j=k=N-1 clears op_stb and goes to DRAIN.
    - At most one op transfer per cycle; back-to-back transfers allowed.
  - DRAIN: entered when all ops are issued. Go to DONE when the N*N-th result transfers on out_stb&out_ack.
  - DONE: done=1 for one cycle, then IDLE.
- Result path (active in COMPUTE and DRAIN; results may arrive while ops are still issuing):
  - res_ack <= res_stb & ~res_ack & ~out_stb.
  - In the ack cycle, latch out_value, set out_stb, set out_i/out_j from the result counters ri/rj (row-major, starting 0,0). Results are assumed in order.
  - out_stb stays high with stable data until out_ack; ri/rj advance on the out transfer.
  - A new res_ack is allowed in the same cycle out_stb clears.
- Simultaneous events: op transfer, result ack and output transfer in one cycle are independent and must all take effect.
- Reset mid-operation: returns to IDLE immediately. Array contents become don't-care; the next start reloads them fully.
- x_stb seen in IDLE is not acked.

Optional Feature:
- Macro: MATMUL_SEQ_PERF_EN.
- Defined: adds output port cycle_count (32 bits). It clears on start and increments every cycle while busy, saturating at all-ones. It holds its value in IDLE until the next start; reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package matmul_pkg:
  - state enum {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE}
  - localparams for the default N and W
  - index-width function
- One natural sub-module: matmul_load_port, the per-reader ack generator, element counter and array write enable. It is instantiated twice (A, B).

Test Plan:
- Identity: A=I (N=4), B=ramp 1..16; MAC model with 2-cycle op_ack and 3-cycle result latency -> out stream C=B in row-major order, indices (0,0)..(3,3), 64 op transfers, single done pulse, busy low after.
- Skewed load: reader B delays its first stb by 40 cycles -> no op_stb until B count=16; a_ack/b_ack each pulse exactly 16 times, never on consecutive cycles.
- Backpressure: out_ack held low 20 cycles on the first result -> out_value/out_i/out_j stable, res_ack low while out_stb high; no result lost; total 16 outputs.
- Op flags: N=2, always-ready MAC -> op_first on k=0 and op_last on k=1, for pairs (A00,B00),(A01,B10),(A00,B01),... in i,j,k order.
- Mid-run reset: rst_n low in COMPUTE after 10 ops -> all outputs 0 the same cycle. A restart then gives a correct full result.
- PERF_EN build: fixed-latency MAC -> cycle_count equals the cycles from the start acceptance to done and holds in IDLE.
